// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seg_scan_ctrl display driver: blank code, FSM
// encoding and the double-dabble nibble correction.
package seg_scan_ctrl_pkg;

  localparam logic [3:0] SEG_BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_e;

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_dd_core.sv
// Sequential double-dabble binary-to-BCD converter: one add-3/shift step per
// cycle, BIN_W steps per conversion. done_o flags the cycle of the last step.
module bcd_dd_core
  import seg_scan_ctrl_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(1);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    adj    = '0;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      adj[4*k +: 4] = dd_adjust(bcd_q[4*k +: 4]);
    end
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = ITERS;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d  = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_d  = bin_q << 1;
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Captures a binary value, converts it to BCD via bcd_dd_core, and
// time-multiplexes the digits (leading zeros blanked) onto a common-anode display.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic [3:0]            digit_bcd,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic             pend_q, pend_d;
  logic [BIN_W-1:0] pend_val_q, pend_val_d;
  logic [BCD_W-1:0] disp_q, disp_d;

  logic             core_start;
  logic [BIN_W-1:0] core_bin;
  logic             core_busy;
  logic             core_done;
  logic [BCD_W-1:0] core_bcd;

  bcd_dd_core #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (core_start),
    .bin_i   (core_bin),
    .busy_o  (core_busy),
    .done_o  (core_done),
    .bcd_o   (core_bcd)
  );

  // A load landing in COMMIT is newer than any pending value, so it wins.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    core_start = 1'b0;
    core_bin   = bin_in;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          core_start = 1'b1;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = bin_in;
        end
        if (core_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d = core_bcd;
        if (load || pend_q) begin
          core_start = 1'b1;
          core_bin   = load ? bin_in : pend_val_q;
          pend_d     = 1'b0;
          state_d    = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the display registers are reset explicitly; they are a handful of
  // flops, not a RAM, and the first scan must show a defined "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
    end
  end

  assign busy = core_busy || (state_q == ST_COMMIT);

  logic [NUM_DIGITS-1:0] blank;
  logic                  nz_above;

  // Digit k is blank when it and every more-significant digit are zero.
  always_comb begin
    blank    = '0;
    nz_above = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      nz_above = nz_above | (|disp_q[4*k +: 4]);
      blank[k] = !nz_above;
    end
  end

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         lit_idx_q, lit_idx_d;
  logic                  lit_q, lit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic                  tick;
  logic [3:0]            next_code, lit_code;

  assign tick = (pre_q == PRE_TC);

  always_comb begin
    next_code = blank[idx_q] ? SEG_BLANK_CODE : disp_q[4*idx_q +: 4];
    lit_code  = blank[lit_idx_q] ? SEG_BLANK_CODE : disp_q[4*lit_idx_q +: 4];
    pre_d     = tick ? '0 : pre_q + 1'b1;
    idx_d     = idx_q;
    lit_idx_d = lit_idx_q;
    lit_d     = lit_q;
    an_d      = an_q;
    digit_d   = lit_q ? lit_code : SEG_BLANK_CODE;
    if (tick) begin
      an_d      = ~(NUM_DIGITS'(1) << idx_q);
      digit_d   = next_code;
      lit_idx_d = idx_q;
      lit_d     = 1'b1;
      idx_d     = (idx_q == IDX_TOP) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      idx_q     <= '0;
      lit_idx_q <= '0;
      lit_q     <= 1'b0;
      an_q      <= '1;
      digit_q   <= SEG_BLANK_CODE;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      lit_idx_q <= lit_idx_d;
      lit_q     <= lit_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
    end
  end

  assign an        = an_q;
  assign digit_bcd = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4: scan order, conversion
// latency, pending/commit-cycle loads, blanking, mid-conversion reset, random values.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       busy;
  logic [3:0] digit_bcd;
  logic [3:0] an;

  int vectors = 0;
  int miscompares = 0;

  seg_scan_ctrl #(
    .BIN_W       (8),
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bin_in    (bin_in),
    .busy      (busy),
    .digit_bcd (digit_bcd),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {d3,d2,d1,d0} for a value 0..255 with leading-zero blanking.
  function automatic logic [15:0] model_disp(input int unsigned v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = (v >= 10)  ? 4'((v / 10) % 10) : 4'hF;
    r[11:8]  = (v >= 100) ? 4'((v / 100) % 10) : 4'hF;
    r[15:12] = 4'hF;
    return r;
  endfunction

  // One full scan rotation (16 cycles) plus one; collects each lit digit.
  task automatic read_display(output logic [15:0] seen, output logic onehot_ok);
    seen = 16'hxxxx;
    onehot_ok = 1'b1;
    repeat (17) begin
      @(negedge clk);
      case (an)
        4'b1110: seen[3:0]   = digit_bcd;
        4'b1101: seen[7:4]   = digit_bcd;
        4'b1011: seen[11:8]  = digit_bcd;
        4'b0111: seen[15:12] = digit_bcd;
        default: onehot_ok   = 1'b0;
      endcase
    end
  endtask

  task automatic pulse_load(input logic [7:0] v);
    bin_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 60) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  logic [15:0] disp;
  logic        oh;
  int          cyc;
  int          w;
  int          busy_cnt;
  logic        seen7;
  logic        bad;
  int unsigned rv;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_an", an, 4'b1111);
    check("rst_digit", digit_bcd, 4'hF);

    rst_n = 1'b1;
    @(negedge clk);
    check("pre_tick_an", an, 4'b1111);
    repeat (2) @(negedge clk);
    check("last_pre_tick_an", an, 4'b1111);
    @(negedge clk);
    check("scan0_an", an, 4'b1110);
    check("scan0_digit", digit_bcd, 4'h0);
    repeat (4) @(negedge clk);
    check("scan1_an", an, 4'b1101);
    check("scan1_digit", digit_bcd, 4'hF);
    repeat (4) @(negedge clk);
    check("scan2_an", an, 4'b1011);
    check("scan2_digit", digit_bcd, 4'hF);
    repeat (4) @(negedge clk);
    check("scan3_an", an, 4'b0111);
    check("scan3_digit", digit_bcd, 4'hF);
    repeat (4) @(negedge clk);
    check("scan_wrap_an", an, 4'b1110);
    check("scan_wrap_digit", digit_bcd, 4'h0);

    pulse_load(8'd255);
    wait_idle(cyc);
    check("busy_len_255", 16'(cyc), 16'd9);
    read_display(disp, oh);
    check("disp_255", disp, 16'hF255);
    check("onehot_255", oh, 1'b1);

    // Align to the scan so digit 0 is lit while value 7 is on display.
    w = 0;
    while (an === 4'b0111 && w < 40) begin @(negedge clk); w++; end
    while (an !== 4'b0111 && w < 40) begin @(negedge clk); w++; end
    check("scan_sync", an, 4'b0111);
    repeat (10) @(negedge clk);
    bin_in = 8'd7;
    load   = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    busy_cnt = 0;
    seen7    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an === 4'b1110 && digit_bcd === 4'd7) seen7 = 1'b1;
      if (busy !== 1'b1) break;
      busy_cnt++;
      if (i == 2) begin
        bin_in = 8'd200;
        load   = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_len_7_200", 16'(busy_cnt), 16'd18);
    check("seen_7", seen7, 1'b1);
    read_display(disp, oh);
    check("disp_200", disp, 16'hF200);

    pulse_load(8'd100);
    wait_idle(cyc);
    check("busy_len_100", 16'(cyc), 16'd9);
    read_display(disp, oh);
    check("disp_100", disp, 16'hF100);

    pulse_load(8'd0);
    wait_idle(cyc);
    read_display(disp, oh);
    check("disp_0", disp, 16'hFFF0);

    // Load arriving exactly in the COMMIT cycle restarts the conversion.
    pulse_load(8'd5);
    repeat (8) @(negedge clk);
    bin_in = 8'd9;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("commit_load_busy", busy, 1'b1);
    wait_idle(cyc);
    check("busy_len_commit_load", 16'(cyc), 16'd9);
    read_display(disp, oh);
    check("disp_9", disp, 16'hFFF9);

    pulse_load(8'd123);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_an", an, 4'b1111);
    check("midrst_digit", digit_bcd, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) bad = 1'b1;
      if (digit_bcd === 4'd1 || digit_bcd === 4'd2 || digit_bcd === 4'd3) bad = 1'b1;
    end
    check("midrst_no_123", bad, 1'b0);
    read_display(disp, oh);
    check("midrst_disp", disp, 16'hFFF0);
    check("midrst_onehot", oh, 1'b1);

    repeat (4) begin
      rv = $urandom_range(0, 255);
      pulse_load(8'(rv));
      wait_idle(cyc);
      check("rand_busy_len", 16'(cyc), 16'd9);
      read_display(disp, oh);
      check("rand_disp", disp, model_disp(rv));
      check("rand_onehot", oh, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
